// File: rtl/serial_to_parallel_32_bit.sv
// Serial-to-parallel front end: collects a framed bit stream into a WIDTH-bit word for the data register.
// Optional trailing even-parity check is compiled in with `define PARITY_CHECK_EN.
module serial_to_parallel_32_bit #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Serial_In,
  input  logic             Serial_Valid,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Load,
  output logic             Busy
`ifdef PARITY_CHECK_EN
  ,
  output logic             Parity_Error
`endif
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_shift, data_d;
  logic             load_d;
`ifdef PARITY_CHECK_EN
  logic             perr_q, perr_d;
`endif

  // Bit order only changes which end of the shift register the new bit enters.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sr_shift = {sr_q[WIDTH-2:0], Serial_In};
    end else begin : g_lsb_first
      assign sr_shift = {Serial_In, sr_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      Data_Out <= '0;
      Load     <= 1'b0;
`ifdef PARITY_CHECK_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      Data_Out <= data_d;
      Load     <= load_d;
`ifdef PARITY_CHECK_EN
      perr_q   <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    data_d  = Data_Out;
    load_d  = 1'b0;
`ifdef PARITY_CHECK_EN
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // Start mid-frame restarts the count; the partial word is simply overwritten.
        if (Start) begin
          cnt_d = '0;
        end else if (Serial_Valid) begin
          sr_d  = sr_shift;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d = IDLE;
            data_d  = sr_shift;
            load_d  = 1'b1;
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (Start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else if (Serial_Valid) begin
          state_d = IDLE;
          if (^{sr_q, Serial_In}) begin
            perr_d = 1'b1;
          end else begin
            data_d = sr_q;
            load_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign Busy = (state_q != IDLE);
`ifdef PARITY_CHECK_EN
  assign Parity_Error = perr_q;
`endif

endmodule

// File: tb/tb_serial_to_parallel_32_bit.sv
// Scoreboard bench: MSB-first and LSB-first instances receive the same words in their own bit order.
module tb_serial_to_parallel_32_bit;
  localparam int W = 32;
`ifdef PARITY_CHECK_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  typedef struct {
    logic         is_err;
    logic [W-1:0] word;
    int           cyc;
  } exp_t;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic         Start = 1'b0;
  logic         Serial_Valid = 1'b0;
  logic         sin_m = 1'b0, sin_l = 1'b0;
  logic [W-1:0] dout_m, dout_l;
  logic         load_m, load_l, busy_m, busy_l, perr_m, perr_l;

  int           total = 0, bad = 0, cyc = 0;
  exp_t         q[$];
  logic [W-1:0] last = '0;
  logic         prev_pulse = 1'b0;

  serial_to_parallel_32_bit #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Serial_In(sin_m), .Serial_Valid(Serial_Valid),
    .Data_Out(dout_m), .Load(load_m), .Busy(busy_m)
`ifdef PARITY_CHECK_EN
    , .Parity_Error(perr_m)
`endif
  );

  serial_to_parallel_32_bit #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Serial_In(sin_l), .Serial_Valid(Serial_Valid),
    .Data_Out(dout_l), .Load(load_l), .Busy(busy_l)
`ifdef PARITY_CHECK_EN
    , .Parity_Error(perr_l)
`endif
  );

`ifndef PARITY_CHECK_EN
  assign perr_m = 1'b0;
  assign perr_l = 1'b0;
`endif

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Load/Parity_Error pulse must match the head of the queue.
  always @(negedge Clock) begin
    exp_t e;
    if (!Reset) begin
      last       = '0;
      prev_pulse = 1'b0;
    end else if (load_m | load_l | perr_m | perr_l) begin
      chk("double_pulse", 64'(prev_pulse), 64'(0));
      prev_pulse = 1'b1;
      if (q.size() == 0) begin
        chk("unexpected_pulse", 64'(1), 64'(0));
      end else begin
        e = q.pop_front();
        chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
        chk("load_m", 64'(load_m), 64'(!e.is_err));
        chk("load_l", 64'(load_l), 64'(!e.is_err));
        chk("perr_m", 64'(perr_m), 64'(e.is_err));
        chk("perr_l", 64'(perr_l), 64'(e.is_err));
        chk("busy_at_done", 64'({busy_m, busy_l}), 64'(0));
        if (!e.is_err) last = e.word;
        chk("data_m", 64'(dout_m), 64'(last));
        chk("data_l", 64'(dout_l), 64'(last));
      end
    end else begin
      prev_pulse = 1'b0;
      chk("hold_m", 64'(dout_m), 64'(last));
      chk("hold_l", 64'(dout_l), 64'(last));
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic rnd_bits();
    sin_m = 1'($urandom);
    sin_l = 1'($urandom);
  endtask

  // gmask bit i set: one Serial_Valid=0 cycle precedes data bit i.
  task automatic send_frame(input logic [W-1:0] word, input logic [31:0] gmask,
                            input logic pbit, input logic expect_err);
    exp_t e;
    int   s;
    Start = 1'b1; Serial_Valid = 1'b1; rnd_bits();
    tick();
    Start = 1'b0;
    s = cyc;
    chk("busy_in_frame", 64'({busy_m, busy_l}), 64'(2'b11));
    e.is_err = expect_err;
    e.word   = word;
    e.cyc    = s + W + PB + $countones(gmask);
    q.push_back(e);
    for (int i = 0; i < W; i++) begin
      if (gmask[i]) begin
        Serial_Valid = 1'b0; rnd_bits();
        tick();
      end
      Serial_Valid = 1'b1; sin_m = word[W-1-i]; sin_l = word[i];
      tick();
    end
    if (PB != 0) begin
      Serial_Valid = 1'b1; sin_m = pbit; sin_l = pbit;
      tick();
    end
    Serial_Valid = 1'b0;
  endtask

  task automatic send_partial(input logic [W-1:0] word, input int n);
    Start = 1'b1; Serial_Valid = 1'b0;
    tick();
    Start = 1'b0;
    for (int i = 0; i < n; i++) begin
      Serial_Valid = 1'b1; sin_m = word[W-1-i]; sin_l = word[i];
      tick();
    end
    Serial_Valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] w;
    // Reset held with random traffic on the inputs.
    Reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      Start = 1'($urandom); Serial_Valid = 1'($urandom); rnd_bits();
      tick();
      chk("rst_data", 64'({dout_m, dout_l}), 64'(0));
      chk("rst_load", 64'({load_m, load_l}), 64'(0));
      chk("rst_busy", 64'({busy_m, busy_l}), 64'(0));
    end
    Start = 1'b0; Serial_Valid = 1'b0; Reset = 1'b1;
    tick();
    chk("post_rst_data", 64'({dout_m, dout_l}), 64'(0));
    chk("post_rst_busy", 64'({busy_m, busy_l}), 64'(0));

    // Plain frame, then the same frame with 10 scattered gaps (back-to-back starts).
    w = 32'hA5A500FF;
    send_frame(w, 32'h0, ^w, 1'b0);
    send_frame(w, 32'hA2113188, ^w, 1'b0);

    // Abort-and-restart: only the restarted frame loads.
    w = 32'h000000AC;
    send_frame(w, 32'h0, ^w, 1'b0);
    tick();
    send_partial(32'hFFFF_FFFF, 12);
    w = 32'h00000032;
    send_frame(w, 32'h0, ^w, 1'b0);
    tick();

    // Reset mid-frame clears Data_Out without a Load.
    send_partial(32'h1234_5678, 20);
    Reset = 1'b0;
    tick();
    chk("midrst_data", 64'({dout_m, dout_l}), 64'(0));
    chk("midrst_load", 64'({load_m, load_l}), 64'(0));
    chk("midrst_busy", 64'({busy_m, busy_l}), 64'(0));
    Reset = 1'b1;
    tick();
    w = 32'h00000050;
    send_frame(w, 32'h0, ^w, 1'b0);
    tick();

`ifdef PARITY_CHECK_EN
    send_frame(32'h000000AC, 32'h0, 1'b0, 1'b0);
    send_frame(32'h00000020, 32'h0, 1'b0, 1'b1);
    tick();
`endif

    for (int i = 0; i < 4; i++) tick();
    chk("pending_expect", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
